// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: phase encoding and terminal-count helper.
package count_seq_pkg;

    // Phase encoding is visible on the state output, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest legal count for a given modulus (MAX = MOD-1).
    function automatic int max_count(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/count_seq_ctrl_mod_counter.sv
// Modulo-MOD counter datapath: clear, clamped load, increment with wrap or hold at max.
module mod_counter #(
    parameter int MOD  = 100,
    parameter int BITS = $clog2(MOD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    input  logic            ld,
    input  logic [BITS-1:0] ld_val,
    input  logic            wrap,
    output logic [BITS-1:0] cnt,
    output logic            at_max
);
    import count_seq_pkg::*;

    localparam int              MAX   = max_count(MOD);
    localparam logic [BITS-1:0] MAX_V = BITS'(MAX);

    assign at_max = (cnt == MAX_V);

    // Count register: clear beats load beats increment; never leaves 0..MAX.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= (ld_val > MAX_V) ? MAX_V : ld_val;
        end else if (inc) begin
            if (!at_max) begin
                cnt <= cnt + BITS'(1);
            end else if (wrap) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Run-control sequencer: IDLE/RUN/PAUSE/DONE phases driving a modulo counter.
module count_seq_ctrl #(
    parameter int MOD  = 100,
    parameter int BITS = $clog2(MOD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    input  logic            load_en,
    input  logic [BITS-1:0] load_val,
    input  logic            wrap_en,
    output logic [BITS-1:0] count_out,
    output logic [1:0]      state,
    output logic            busy,
    output logic            done,
    output logic            tc
);
    import count_seq_pkg::*;

    state_t cur_state;
    state_t next_state;
    logic   inc;
    logic   clr;
    logic   ld;
    logic   at_max;
    logic   done_d;
    logic   tc_d;

    mod_counter #(
        .MOD  (MOD),
        .BITS (BITS)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc),
        .clr    (clr),
        .ld     (ld),
        .ld_val (load_val),
        .wrap   (wrap_en),
        .cnt    (count_out),
        .at_max (at_max)
    );

    // Phase register plus the registered one-cycle done/tc pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= IDLE;
            done      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            cur_state <= next_state;
            done      <= done_d;
            tc        <= tc_d;
        end
    end

    // Command decode with priority clear > load_en > stop > start.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        next_state = cur_state;
        inc        = 1'b0;
        clr        = 1'b0;
        ld         = 1'b0;
        done_d     = 1'b0;
        tc_d       = 1'b0;
        if (clear) begin
            clr        = 1'b1;
            next_state = IDLE;
        end else begin
            case (cur_state)
                RUN: begin
                    // Loads are ignored while running; stop wins over terminal count.
                    if (stop) begin
                        next_state = PAUSE;
                    end else begin
                        inc = 1'b1;
                        if (at_max) begin
                            if (wrap_en) begin
                                tc_d = 1'b1;
                            end else begin
                                next_state = DONE;
                                done_d     = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (load_en) begin
                        ld         = 1'b1;
                        next_state = IDLE;
                    end else if (!stop && start) begin
                        clr        = 1'b1;
                        next_state = RUN;
                    end
                end
                default: begin
                    // IDLE and PAUSE: load in place, or resume on start.
                    if (load_en) begin
                        ld = 1'b1;
                    end else if (!stop && start) begin
                        next_state = RUN;
                    end
                end
            endcase
        end
    end

    assign state = cur_state;
    assign busy  = (cur_state == RUN);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: MOD=10 and MOD=100 instances against a phase/count model.
module tb_count_seq_ctrl;

    typedef struct {
        int cnt;
        int ph;
        bit dn;
        bit tc;
    } model_t;

    int mods [2] = '{10, 100};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_start [2];
    logic       in_stop  [2];
    logic       in_clear [2];
    logic       in_ld    [2];
    logic [6:0] in_lv    [2];
    logic       in_wrap  [2];

    logic [3:0] cnt0;
    logic [6:0] cnt1;
    logic [1:0] st0, st1;
    logic       busy0, busy1, done0, done1, tc0, tc1;

    model_t mdl [2];
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;

    count_seq_ctrl #(.MOD(10)) dut10 (
        .clk(clk), .rst(rst), .start(in_start[0]), .stop(in_stop[0]), .clear(in_clear[0]),
        .load_en(in_ld[0]), .load_val(in_lv[0][3:0]), .wrap_en(in_wrap[0]),
        .count_out(cnt0), .state(st0), .busy(busy0), .done(done0), .tc(tc0)
    );

    count_seq_ctrl #(.MOD(100)) dut100 (
        .clk(clk), .rst(rst), .start(in_start[1]), .stop(in_stop[1]), .clear(in_clear[1]),
        .load_en(in_ld[1]), .load_val(in_lv[1]), .wrap_en(in_wrap[1]),
        .count_out(cnt1), .state(st1), .busy(busy1), .done(done1), .tc(tc1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Spec-level behaviour of one counter instance for one clock edge.
    function automatic model_t next_model(input model_t m, input int k);
        model_t n  = m;
        int     lv = (k == 0) ? int'(in_lv[0][3:0]) : int'(in_lv[1]);
        int     mx = mods[k] - 1;
        n.dn = 1'b0;
        n.tc = 1'b0;
        if (in_clear[k]) begin
            n.cnt = 0;
            n.ph  = 0;
        end else if (in_ld[k] && m.ph != 1) begin
            n.cnt = (lv > mx) ? mx : lv;
            if (m.ph == 3) n.ph = 0;
        end else if (m.ph == 1) begin
            if (in_stop[k]) begin
                n.ph = 2;
            end else if (m.cnt == mx) begin
                if (in_wrap[k]) begin
                    n.cnt = 0;
                    n.tc  = 1'b1;
                end else begin
                    n.ph = 3;
                    n.dn = 1'b1;
                end
            end else begin
                n.cnt = m.cnt + 1;
            end
        end else if (!in_stop[k] && in_start[k]) begin
            if (m.ph == 3) n.cnt = 0;
            n.ph = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) mdl[k] <= '{cnt: 0, ph: 0, dn: 1'b0, tc: 1'b0};
        end else begin
            for (int k = 0; k < 2; k++) mdl[k] <= next_model(mdl[k], k);
        end
    end

    task automatic cmp(input int k, input logic [31:0] c, input logic [1:0] s,
                       input logic b, input logic d, input logic t);
        check($sformatf("m%0d_count", k), c, mdl[k].cnt);
        check($sformatf("m%0d_state", k), {30'd0, s}, mdl[k].ph);
        check($sformatf("m%0d_busy", k), {31'd0, b}, (mdl[k].ph == 1) ? 1 : 0);
        check($sformatf("m%0d_done", k), {31'd0, d}, {31'd0, mdl[k].dn});
        check($sformatf("m%0d_tc", k), {31'd0, t}, {31'd0, mdl[k].tc});
    endtask

    // Every cycle out of reset, both instances must match the model.
    always @(negedge clk) begin
        if (rst) begin
            cmp(0, {28'd0, cnt0}, st0, busy0, done0, tc0);
            cmp(1, {25'd0, cnt1}, st1, busy1, done1, tc1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_start[k] = 0; in_stop[k] = 0; in_clear[k] = 0;
            in_ld[k] = 0; in_lv[k] = '0; in_wrap[k] = 0;
        end
        #1;
        check("reset_count", {28'd0, cnt0}, 0);
        check("reset_state", {30'd0, st0}, 0);
        check("reset_done_tc", {30'd0, done0, tc0}, 0);
        cyc(2);
        rst = 1'b1;

        // Single-cycle start, saturate at 9.
        in_start[0] = 1; cyc(1); in_start[0] = 0;
        check("start_run_state", {30'd0, st0}, 1);
        check("start_no_inc", {28'd0, cnt0}, 0);
        cyc(9);
        check("run_reach_9", {28'd0, cnt0}, 9);
        cyc(1);
        check("sat_done_state", {30'd0, st0}, 3);
        check("sat_done_pulse", {31'd0, done0}, 1);
        check("sat_busy_low", {31'd0, busy0}, 0);
        cyc(1);
        check("done_one_cycle", {31'd0, done0}, 0);
        check("sat_hold_9", {28'd0, cnt0}, 9);

        // clear and start together in DONE.
        in_clear[0] = 1; in_start[0] = 1; cyc(1); in_clear[0] = 0; in_start[0] = 0;
        check("clear_beats_start", {30'd0, st0}, 0);
        check("clear_count", {28'd0, cnt0}, 0);

        // Wrap from 7.
        in_lv[0] = 7'd7; in_ld[0] = 1; cyc(1); in_ld[0] = 0;
        in_wrap[0] = 1; in_start[0] = 1; cyc(1); in_start[0] = 0;
        cyc(3);
        check("wrap_to_0", {28'd0, cnt0}, 0);
        check("wrap_tc", {31'd0, tc0}, 1);
        check("wrap_stay_run", {30'd0, st0}, 1);
        cyc(1);
        check("wrap_tc_clears", {31'd0, tc0}, 0);

        // Stop at 4, pause three cycles, resume.
        cyc(3);
        in_stop[0] = 1; cyc(1); in_stop[0] = 0;
        check("pause_state", {30'd0, st0}, 2);
        cyc(3);
        check("pause_hold_4", {28'd0, cnt0}, 4);
        in_start[0] = 1; cyc(1); in_start[0] = 0;
        cyc(2);
        check("resume_6", {28'd0, cnt0}, 6);

        // Load ignored in RUN at count 3.
        cyc(7);
        in_lv[0] = 7'd8; in_ld[0] = 1; cyc(1); in_ld[0] = 0;
        check("load_ignored_run", {28'd0, cnt0}, 4);

        // Clamped load, then run from 9 with saturation, then restart from DONE.
        in_clear[0] = 1; cyc(1); in_clear[0] = 0;
        in_lv[0] = 7'd15; in_ld[0] = 1; cyc(1); in_ld[0] = 0;
        check("load_clamp_9", {28'd0, cnt0}, 9);
        in_wrap[0] = 0; in_start[0] = 1; cyc(1); in_start[0] = 0;
        cyc(1);
        check("load_max_done", {30'd0, st0}, 3);
        in_start[0] = 1; cyc(1); in_start[0] = 0;
        check("restart_count_0", {28'd0, cnt0}, 0);
        cyc(1);
        check("restart_count_1", {28'd0, cnt0}, 1);

        // Load in PAUSE, saturate again, load in DONE returns to IDLE.
        in_stop[0] = 1; cyc(1); in_stop[0] = 0;
        in_lv[0] = 7'd12; in_ld[0] = 1; cyc(1); in_ld[0] = 0;
        in_start[0] = 1; cyc(1); in_start[0] = 0;
        cyc(1);
        in_lv[0] = 7'd3; in_ld[0] = 1; cyc(1); in_ld[0] = 0;
        check("done_load_idle", {30'd0, st0}, 0);

        // Asynchronous reset mid-run at count 5.
        in_start[0] = 1; cyc(1); in_start[0] = 0;
        cyc(2);
        check("pre_reset_5", {28'd0, cnt0}, 5);
        #1 rst = 1'b0;
        #1;
        check("async_rst_count", {28'd0, cnt0}, 0);
        check("async_rst_state", {30'd0, st0}, 0);
        check("async_rst_pulses", {30'd0, done0, tc0}, 0);
        cyc(1);
        rst = 1'b1;

        // Wide instance: clamp to 99 and saturate at 99.
        in_lv[1] = 7'd127; in_ld[1] = 1; cyc(1); in_ld[1] = 0;
        check("m100_clamp_99", {25'd0, cnt1}, 99);
        in_start[1] = 1; cyc(1); in_start[1] = 0;
        cyc(1);
        check("m100_done_state", {30'd0, st1}, 3);
        check("m100_done_pulse", {31'd0, done1}, 1);
        in_lv[1] = 7'd97; in_ld[1] = 1; cyc(1); in_ld[1] = 0;
        in_start[1] = 1; cyc(1); in_start[1] = 0;
        cyc(2);
        check("m100_count_99", {25'd0, cnt1}, 99);
        cyc(1);
        check("m100_sat_state", {30'd0, st1}, 3);
        check("m100_sat_hold", {25'd0, cnt1}, 99);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Run-control sequencer for a modulo-MOD up-counter datapath. It takes start, stop, clear and load commands, sequences the counter through idle, run, pause and done phases, and either wraps the count or saturates and reports done. It sits between control logic (buttons, FSMs) and the count display or consumer logic.

Parameters:
MOD, 100, counter modulus; count range 0..MOD-1; MOD >= 2
BITS, $clog2(MOD), count width (7 for MOD=100)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin or resume counting (level sampled each clk)
stop  input  1  pause counting
clear  input  1  synchronous clear to 0 and IDLE
load_en  input  1  load load_val (honoured outside RUN only)
load_val  input  BITS  value to load; clamped to MOD-1
wrap_en  input  1  1 = wrap at MOD-1; 0 = saturate and go DONE
count_out  output  BITS  current count (registered)
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
busy  output  1  state==RUN (combinational decode of state reg)
done  output  1  one-cycle pulse on entry to DONE
tc  output  1  one-cycle pulse on wrap from MOD-1 to 0

Behaviour:
- Reset (rst=0, async): state IDLE, count_out 0, done 0, tc 0. Deassertion is synchronous to clk at the integration level.
- Command priority each edge: clear > load_en > stop > start.
- clear (any state): next edge count_out=0, state IDLE; overrides increment and wrap; no done/tc pulse.
- load_en in IDLE/PAUSE/DONE: count_out = min(load_val, MOD-1). State unchanged except DONE -> IDLE. Ignored in RUN.
- IDLE: start -> RUN; count unchanged on that edge.
- RUN: count_out +1 every edge. At count MOD-1:
  wrap_en=1 -> count 0, tc=1 next cycle, stay RUN.
  wrap_en=0 -> count held at MOD-1, state DONE, done=1 next cycle.
  stop -> PAUSE with no increment on that edge; stop beats terminal-count handling. start while in RUN is ignored.
- PAUSE: count held; start -> RUN; stop ignored.
- DONE: count held at MOD-1; start -> count 0, state RUN (restart). Level-held start does not retrigger until DONE is re-entered.
- Latency: start sampled at edge N gives RUN after N. The first increment occurs at edge N+1.
- wrap_en is sampled only at the terminal-count edge. Changing it mid-run has no other effect.
- done and tc are registered, high exactly one cycle, never simultaneous.
- Entering RUN from IDLE or load with count already MOD-1 and wrap_en=0: DONE at the first increment edge.
- No count_out value outside 0..MOD-1 is ever produced.

Decomposition:
- Package count_seq_pkg holds the state encoding (IDLE/RUN/PAUSE/DONE as 2-bit constants) and the helper constant MAX = MOD-1.
- Sub-module mod_counter (clk, rst, inc, clr, ld, ld_val, wrap -> cnt, at_max) is the datapath.
- count_seq_ctrl holds the FSM and the done/tc pulse registers, and drives mod_counter.

Test Plan (MOD=10 unless noted):
- Reset mid-RUN at count 5: drive rst=0 asynchronously between edges. count_out=0 and state=IDLE immediately; done=tc=0.
- start one cycle, wrap_en=0, from 0: count 1..9 on 9 successive edges, then DONE. done high exactly one cycle; count stays 9; busy=0.
- wrap_en=1, run from 7: counts 8, 9, 0, 1. tc high only for the cycle count=0. state stays RUN; done never asserts.
- stop at count 4 in RUN: count holds 4 in PAUSE for 3 cycles. start gives RUN, then 5, 6.
- load_val=15 in IDLE gives count 9 (clamped). load_en in RUN at count 3 is ignored; the next count is 4.
- clear and start together in DONE: IDLE, count 0. Then start alone in DONE (re-reach it): RUN with count 0, then 1. MOD=100 build: verify BITS=7 and a saturating stop at 99.
